// File: rtl/basemul_acc_ctrl_fsm_if.sv
// Handshake/control bundle between host-side load/readout logic and the
// basemul/accumulate control FSM. The FSM sits on the slave modport.
interface basemul_acc_ctrl_fsm_if #(
  parameter int DEPTH = 8,
  parameter int KW    = 3
);
  logic             set;
  logic             start;
  logic [KW-1:0]    k_cfg;
  logic             full_in;
  logic             cal_en;
  logic             readout_done;

  logic [DEPTH-1:0] counter;
  logic [KW-1:0]    pass_idx;
  logic             iscal;
  logic             index_ab_ctrl;
  logic             index_c_ctrl;
  logic             rama_we_ok;
  logic             ramb_we_ok;
  logic             ramc_we_ok;
  logic             acc_en;
  logic             tomont_sel;
  logic             readin_ok;
  logic             cal_pulse;
  logic             done;
  logic             cfg_err;

  modport master (
    output set, start, k_cfg, full_in, cal_en, readout_done,
    input  counter, pass_idx, iscal, index_ab_ctrl, index_c_ctrl,
           rama_we_ok, ramb_we_ok, ramc_we_ok, acc_en, tomont_sel,
           readin_ok, cal_pulse, done, cfg_err
  );

  modport slave (
    input  set, start, k_cfg, full_in, cal_en, readout_done,
    output counter, pass_idx, iscal, index_ab_ctrl, index_c_ctrl,
           rama_we_ok, ramb_we_ok, ramc_we_ok, acc_en, tomont_sel,
           readin_ok, cal_pulse, done, cfg_err
  );
endinterface

// File: rtl/basemul_acc_ctrl_fsm.sv
// basemul_acc_ctrl_fsm: sequences k load/compute passes of A*B into RAM C
// (pass 0 overwrites, later passes accumulate), then hands C to readout.
// Define BMACC_TOMONT_EN to add a tomont pass over C before readout.
//
// state      | meaning
// IDLE       | waiting for start
// LOAD_REQ   | one-cycle load request to host, A/B writable
// LOAD_WAIT  | host loading A/B, waiting for full_in
// ARM        | A/B frozen, waiting for cal_en
// CLR        | one-cycle clear of core index/pipeline
// COMP       | basemul pass, counter sweeps 0..LAST
// NEXT       | pass bookkeeping: next pass or finish
// TOMONT_CLR | one-cycle clear before tomont pass (optional)
// TOMONT     | tomont pass over C (optional)
// DONE       | C valid, readout owns C
module basemul_acc_ctrl_fsm #(
  parameter int DEPTH    = 8,
  parameter int PIPE_LAT = 4,
  parameter int KW       = 3,
  parameter int K_MAX    = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  basemul_acc_ctrl_fsm_if.slave bus
);
  localparam logic [DEPTH-1:0] PASS_LEN = DEPTH'(1 << (DEPTH-1));
  localparam logic [DEPTH-1:0] PIPE     = DEPTH'(PIPE_LAT);
  localparam logic [DEPTH-1:0] LAST     = DEPTH'((1 << (DEPTH-1)) + PIPE_LAT - 1);
  localparam logic [KW-1:0]    KMAX     = KW'(K_MAX);
  localparam logic [KW-1:0]    ONE      = KW'(1);

  typedef enum logic [3:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, ARM, CLR, COMP, NEXT, DONE
`ifdef BMACC_TOMONT_EN
    , TOMONT_CLR, TOMONT
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [DEPTH-1:0] counter, counter_nxt;
  logic [KW-1:0]    pass_idx, pass_nxt, k_eff, k_eff_nxt, pass_inc, k_clamp;
  logic             cfg_err, cfg_err_nxt, k_bad, take;
  logic             c_win;

  assign k_bad    = (bus.k_cfg == '0) || (bus.k_cfg > KMAX);
  assign k_clamp  = (bus.k_cfg == '0) ? ONE : ((bus.k_cfg > KMAX) ? KMAX : bus.k_cfg);
  assign pass_inc = pass_idx + ONE;
  assign c_win    = (counter >= PIPE);

  // state/counter/pass registers; set low freezes everything
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= '0;
      pass_idx <= '0;
      k_eff    <= '0;
      cfg_err  <= 1'b0;
    end else if (bus.set) begin
      state    <= state_nxt;
      counter  <= counter_nxt;
      pass_idx <= pass_nxt;
      k_eff    <= k_eff_nxt;
      cfg_err  <= cfg_err_nxt;
    end
  end

  // next-state: counter is zero everywhere except while sweeping a pass
  always_comb begin
    state_nxt   = state;
    counter_nxt = '0;
    pass_nxt    = pass_idx;
    k_eff_nxt   = k_eff;
    cfg_err_nxt = cfg_err;
    take        = 1'b0;
    case (state)
      IDLE:      if (bus.start) take = 1'b1;
      LOAD_REQ:  state_nxt = LOAD_WAIT;
      LOAD_WAIT: if (bus.full_in) state_nxt = ARM;
      ARM:       if (bus.cal_en) state_nxt = CLR;
      CLR:       state_nxt = COMP;
      COMP: begin
        if (counter == LAST) state_nxt = NEXT;
        else counter_nxt = counter + DEPTH'(1);
      end
      NEXT: begin
        if (pass_inc < k_eff) begin
          pass_nxt  = pass_inc;
          state_nxt = LOAD_REQ;
        end else begin
`ifdef BMACC_TOMONT_EN
          state_nxt = TOMONT_CLR;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef BMACC_TOMONT_EN
      TOMONT_CLR: state_nxt = TOMONT;
      TOMONT: begin
        if (counter == LAST) state_nxt = DONE;
        else counter_nxt = counter + DEPTH'(1);
      end
`endif
      DONE: begin
        if (bus.readout_done && bus.start) take = 1'b1;
        else if (bus.readout_done) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
    if (take) begin
      state_nxt   = LOAD_REQ;
      pass_nxt    = '0;
      k_eff_nxt   = k_clamp;
      cfg_err_nxt = k_bad;
    end
  end

  logic readin_ok, cal_pulse, iscal, index_ab_ctrl, index_c_ctrl;
  logic rama_we_ok, ramb_we_ok, ramc_we_ok, acc_en, tomont_sel, done;

  // Moore output decode from registered state/counter/pass_idx only
  always_comb begin
    readin_ok     = 1'b0;
    cal_pulse     = 1'b0;
    iscal         = 1'b0;
    index_ab_ctrl = 1'b0;
    index_c_ctrl  = 1'b0;
    rama_we_ok    = 1'b0;
    ramb_we_ok    = 1'b0;
    ramc_we_ok    = 1'b0;
    acc_en        = 1'b0;
    tomont_sel    = 1'b0;
    done          = 1'b0;
    case (state)
      LOAD_REQ: begin
        readin_ok  = 1'b1;
        rama_we_ok = 1'b1;
        ramb_we_ok = 1'b1;
      end
      LOAD_WAIT: begin
        rama_we_ok = 1'b1;
        ramb_we_ok = 1'b1;
      end
      CLR: cal_pulse = 1'b1;
      COMP: begin
        iscal         = 1'b1;
        index_ab_ctrl = (counter < PASS_LEN);
        ramc_we_ok    = c_win;
        index_c_ctrl  = c_win;
        acc_en        = (pass_idx != '0);
      end
`ifdef BMACC_TOMONT_EN
      TOMONT_CLR: cal_pulse = 1'b1;
      TOMONT: begin
        iscal        = 1'b1;
        tomont_sel   = 1'b1;
        ramc_we_ok   = c_win;
        index_c_ctrl = c_win;
      end
`endif
      DONE: begin
        done         = 1'b1;
        index_c_ctrl = 1'b1;
        rama_we_ok   = 1'b1;
        ramb_we_ok   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.counter       = counter;
  assign bus.pass_idx      = pass_idx;
  assign bus.cfg_err       = cfg_err;
  assign bus.readin_ok     = readin_ok;
  assign bus.cal_pulse     = cal_pulse;
  assign bus.iscal         = iscal;
  assign bus.index_ab_ctrl = index_ab_ctrl;
  assign bus.index_c_ctrl  = index_c_ctrl;
  assign bus.rama_we_ok    = rama_we_ok;
  assign bus.ramb_we_ok    = ramb_we_ok;
  assign bus.ramc_we_ok    = ramc_we_ok;
  assign bus.acc_en        = acc_en;
  assign bus.tomont_sel    = tomont_sel;
  assign bus.done          = done;
endmodule

// File: tb/tb_basemul_acc_ctrl_fsm.sv
// Directed bench for basemul_acc_ctrl_fsm (DEPTH=8, PIPE_LAT=4, K_MAX=4).
module tb_basemul_acc_ctrl_fsm;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;

  basemul_acc_ctrl_fsm_if #(.DEPTH(8), .KW(3)) bus ();

  basemul_acc_ctrl_fsm #(.DEPTH(8), .PIPE_LAT(4), .KW(3), .K_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // output bit order: readin cal iscal done rama ramb ramc acc iab ic tom err
  localparam logic [11:0] O_LREQ  = 12'b1000_1100_0000;
  localparam logic [11:0] O_LWAIT = 12'b0000_1100_0000;
  localparam logic [11:0] O_CLR   = 12'b0100_0000_0000;
  localparam logic [11:0] O_COMP0 = 12'b0010_0000_1000;
  localparam logic [11:0] O_DONE  = 12'b0001_1100_0100;

  typedef struct {
    logic        st, fi, ce, rd;
    logic [2:0]  k;
    logic [11:0] eo;
    int          ec;
  } vec_t;
  vec_t vt[9];

  function automatic logic [11:0] outs();
    return {bus.readin_ok, bus.cal_pulse, bus.iscal, bus.done, bus.rama_we_ok,
            bus.ramb_we_ok, bus.ramc_we_ok, bus.acc_en, bus.index_ab_ctrl,
            bus.index_c_ctrl, bus.tomont_sel, bus.cfg_err};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one compute/tomont sweep starting from the observed counter-0 cycle.
  task automatic comp_pass(input bit exp_acc, input bit tom, input int freeze_at,
                           input int abort_at, output bit aborted);
    int n = 0, w = 0, first = -1, last = -1;
    int cnt_bad = 0, acc_bad = 0, ab_bad = 0, c_bad = 0, fz_bad = 0;
    bit froze = 0;
    aborted = 0;
    while (bus.iscal === 1'b1 && n < 300) begin
      if (int'(bus.counter) != n) cnt_bad++;
      if (bus.acc_en !== exp_acc || bus.tomont_sel !== tom) acc_bad++;
      if (bus.index_ab_ctrl !== ((!tom) && (n < 128))) ab_bad++;
      if (bus.ramc_we_ok !== (n >= 4) || bus.index_c_ctrl !== (n >= 4)) c_bad++;
      if (bus.ramc_we_ok === 1'b1) begin
        w++;
        if (first < 0) first = n;
        last = n;
      end
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_outs", outs(), 0);
        check("rst_counter", bus.counter, 0);
        check("rst_pass_idx", bus.pass_idx, 0);
        step();
        step();
        reset_n = 1'b1;
        aborted = 1;
        return;
      end
      if (n == freeze_at && !froze) begin
        froze = 1;
        bus.set = 1'b0;
        bus.start = 1'b1;
        for (int f = 0; f < 10; f++) begin
          step();
          if (int'(bus.counter) != freeze_at || bus.iscal !== 1'b1 || bus.ramc_we_ok !== 1'b1) fz_bad++;
        end
        bus.set = 1'b1;
        bus.start = 1'b0;
      end
      n++;
      step();
    end
    check("comp_cycles", n, 132);
    check("wr_count", w, 128);
    check("wr_first", first, 4);
    check("wr_last", last, 131);
    check("cnt_seq_errs", cnt_bad, 0);
    check("acc_tom_errs", acc_bad, 0);
    check("index_ab_errs", ab_bad, 0);
    check("ramc_win_errs", c_bad, 0);
    if (freeze_at >= 0) begin
      check("freeze_hold_errs", fz_bad, 0);
      check("froze", froze, 1);
    end
  endtask

  // Precondition: final NEXT observed (or DONE for tomont builds after sweep).
  task automatic finish_job(input int exp_last, input bit err);
    bit ab;
    check("next", outs(), {11'b0, err});
    step();
`ifdef BMACC_TOMONT_EN
    check("tomont_clr", outs(), O_CLR | {11'b0, err});
    step();
    comp_pass(1'b0, 1'b1, -1, -1, ab);
`endif
    check("done", outs(), O_DONE | {11'b0, err});
    check("done_pass_idx", bus.pass_idx, exp_last);
  endtask

  task automatic run_job(input logic [2:0] k, input int exp_k, input bit err,
                         input bit with_rd, input int abort_pass, output bit ab);
    ab = 0;
    bus.k_cfg = k;
    bus.start = 1'b1;
    bus.readout_done = with_rd;
    step();
    bus.start = 1'b0;
    bus.readout_done = 1'b0;
    for (int p = 0; p < exp_k; p++) begin
      check("load_req", outs(), O_LREQ | {11'b0, err});
      check("pass_idx", bus.pass_idx, p);
      step();
      check("load_wait", outs(), O_LWAIT | {11'b0, err});
      bus.full_in = 1'b1;
      step();
      bus.full_in = 1'b0;
      check("arm", outs(), {11'b0, err});
      bus.cal_en = 1'b1;
      step();
      bus.cal_en = 1'b0;
      check("clr", outs(), O_CLR | {11'b0, err});
      step();
      comp_pass(p != 0, 1'b0, -1, (p == abort_pass) ? 60 : -1, ab);
      if (ab) return;
      if (p < exp_k - 1) begin
        check("next_mid", outs(), {11'b0, err});
        step();
      end
    end
    finish_job(exp_k - 1, err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ab;
    vt[0] = '{st:0, fi:0, ce:0, rd:0, k:3'd0, eo:12'b0,  ec:0};
    vt[1] = '{st:0, fi:1, ce:1, rd:1, k:3'd0, eo:12'b0,  ec:0};
    vt[2] = '{st:1, fi:0, ce:0, rd:0, k:3'd1, eo:O_LREQ, ec:0};
    vt[3] = '{st:0, fi:0, ce:1, rd:0, k:3'd1, eo:O_LWAIT, ec:0};
    vt[4] = '{st:0, fi:0, ce:0, rd:0, k:3'd1, eo:O_LWAIT, ec:0};
    vt[5] = '{st:0, fi:1, ce:0, rd:0, k:3'd1, eo:12'b0,  ec:0};
    vt[6] = '{st:1, fi:0, ce:0, rd:0, k:3'd1, eo:12'b0,  ec:0};
    vt[7] = '{st:0, fi:0, ce:1, rd:0, k:3'd1, eo:O_CLR,  ec:0};
    vt[8] = '{st:0, fi:0, ce:0, rd:0, k:3'd1, eo:O_COMP0, ec:0};

    reset_n = 1'b0;
    bus.set = 1'b1;
    bus.start = 1'b0;
    bus.k_cfg = 3'd0;
    bus.full_in = 1'b0;
    bus.cal_en = 1'b0;
    bus.readout_done = 1'b0;
    #1;
    check("reset_outs", outs(), 0);
    check("reset_counter", bus.counter, 0);
    step();
    step();
    reset_n = 1'b1;

    // k=1 job, early full_in/cal_en ignored, freeze mid-sweep
    for (int i = 0; i < 9; i++) begin
      bus.start = vt[i].st;
      bus.full_in = vt[i].fi;
      bus.cal_en = vt[i].ce;
      bus.readout_done = vt[i].rd;
      bus.k_cfg = vt[i].k;
      step();
      check($sformatf("vec%0d_outs", i), outs(), vt[i].eo);
      check($sformatf("vec%0d_cnt", i), bus.counter, vt[i].ec);
    end
    bus.start = 1'b0;
    bus.full_in = 1'b0;
    bus.cal_en = 1'b0;
    bus.readout_done = 1'b0;
    comp_pass(1'b0, 1'b0, 50, -1, ab);
    finish_job(0, 1'b0);

    // DONE: start alone ignored, readout_done alone returns to IDLE
    bus.start = 1'b1;
    bus.k_cfg = 3'd3;
    step();
    bus.start = 1'b0;
    check("start_ignored", outs(), O_DONE);
    bus.readout_done = 1'b1;
    step();
    bus.readout_done = 1'b0;
    check("rd_to_idle", outs(), 0);

    run_job(3'd3, 3, 1'b0, 1'b0, -1, ab);
    run_job(3'd0, 1, 1'b1, 1'b1, -1, ab);
    run_job(3'd7, 4, 1'b1, 1'b1, -1, ab);

    // valid start clears cfg_err; reset mid-pass 1 at counter 60
    run_job(3'd2, 2, 1'b0, 1'b1, 1, ab);
    check("aborted", ab, 1);
    check("post_rst_idle", outs(), 0);
    step();
    check("post_rst_idle2", outs(), 0);
    check("post_rst_pass", bus.pass_idx, 0);
    run_job(3'd2, 2, 1'b0, 1'b0, -1, ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
